// File: rtl/lsu_ram_master_if.sv
// Pipeline request/response channel and RAM word-port strobes of the LSU RAM master.
// The master modport is the LSU side; the slave modport is the pipeline/RAM environment.
interface lsu_ram_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] ram_wdat;
  logic        ram_we;
  logic        ram_re;
  logic [3:0]  ram_type;
  logic [31:0] ram_addr;
  logic [31:0] ram_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_wdat, ram_we, ram_re, ram_type, ram_addr
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_wdat, ram_we, ram_re, ram_type, ram_addr
  );
endinterface

// File: rtl/lsu_ram_master.sv
// Load/store initiator for the data-RAM word port: byte enables, lane shifting,
// two-beat split of misaligned accesses, and load reassembly with sign/zero extension.
module lsu_ram_master (
  input  logic             clk,
  input  logic             rst_n,
  lsu_ram_master_if.master bus
);

  typedef enum logic [2:0] {StIdle, StAcc0, StAcc1, StCap, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf0_q, buf0_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  off;
  logic        illegal;
  logic        split;
  logic [3:0]  base_mask;
  logic [7:0]  mask8;
  logic [63:0] wdat64;
  logic [31:0] word0, word1;
  logic [63:0] rd64;
  logic [31:0] rd_sh;
  logic [31:0] load_val;

  assign off   = addr_q[1:0];
  assign word0 = {addr_q[31:2], 2'b00};
  assign word1 = word0 + 32'd4;

  always_comb begin
    if (bus.req_we) begin
      illegal = (bus.req_funct3 > 3'd2);
    end else begin
      illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  // The upper half of the shifted mask/data is the second word when the access straddles.
  assign mask8  = {4'b0000, base_mask} << off;
  assign wdat64 = {32'b0, wdata_q} << {off, 3'b000};
  assign split  = ((funct3_q[1:0] == 2'b01) && (off == 2'd3)) ||
                  ((funct3_q[1:0] == 2'b10) && (off != 2'd0));

  assign rd64  = split ? {bus.ram_rdata, buf0_q} : {32'b0, bus.ram_rdata};
  assign rd_sh = 32'(rd64 >> {off, 3'b000});

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  load_val = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  load_val = {24'b0, rd_sh[7:0]};
      3'b101:  load_val = {16'b0, rd_sh[15:0]};
      default: load_val = rd_sh;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf0_d   = buf0_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.ram_wdat   = '0;
    bus.ram_we     = 1'b0;
    bus.ram_re     = 1'b0;
    bus.ram_type   = '0;
    bus.ram_addr   = '0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (illegal) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = StResp;
          end else begin
            state_d = StAcc0;
          end
        end
      end
      StAcc0: begin
        bus.ram_addr = word0;
        bus.ram_type = mask8[3:0];
        bus.ram_wdat = wdat64[31:0];
        bus.ram_we   = we_q;
        bus.ram_re   = ~we_q;
        if (split) begin
          state_d = StAcc1;
        end else begin
          state_d = we_q ? StResp : StCap;
        end
      end
      StAcc1: begin
        bus.ram_addr = word1;
        bus.ram_type = mask8[7:4];
        bus.ram_wdat = wdat64[63:32];
        bus.ram_we   = we_q;
        bus.ram_re   = ~we_q;
        // Beat-0 read data is on the RAM output during this cycle.
        if (!we_q) begin
          buf0_d = bus.ram_rdata;
        end
        state_d = we_q ? StResp : StCap;
      end
      StCap: begin
        rdata_d = load_val;
        state_d = StResp;
      end
      StResp: begin
        bus.resp_valid = 1'b1;
        rdata_d        = '0;
        err_d          = 1'b0;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf0_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf0_q   <= buf0_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Scoreboard bench for lsu_ram_master: a byte-addressed reference memory predicts RAM beats
// and responses; a monitor pops and compares whenever the DUT strobes the RAM or responds.
module tb_lsu_ram_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_ram_master_if bus ();

  lsu_ram_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdat;
  } beat_t;

  resp_t resp_q[$];
  beat_t beat_q[$];

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int acc_cyc = 0;

  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] ram_mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (be[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Word-port RAM with registered read data.
  initial begin
    logic [31:0] w;
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_re) bus.ram_rdata <= ram_rd(bus.ram_addr);
      if (bus.ram_we) begin
        w = ram_rd(bus.ram_addr);
        for (int i = 0; i < 4; i++) if (bus.ram_type[i]) w[i*8 +: 8] = bus.ram_wdat[i*8 +: 8];
        ram_mem[bus.ram_addr] = w;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
      cyc++;
    end
  end

  // Monitor.
  initial begin
    beat_t b;
    resp_t r;
    forever begin
      @(negedge clk);
      if (bus.ram_we || bus.ram_re) begin
        chk("strobe_excl", 32'(bus.ram_we & bus.ram_re), 32'd0);
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 32'd1, 32'd0);
        end else begin
          b = beat_q.pop_front();
          chk("beat_addr", bus.ram_addr, b.addr);
          chk("beat_type", 32'(bus.ram_type), 32'(b.be));
          chk("beat_we", 32'(bus.ram_we), 32'(b.we));
          chk("beat_re", 32'(bus.ram_re), 32'(!b.we));
          if (b.we) chk("beat_wdat", bus.ram_wdat & lane_mask(b.be), b.wdat & lane_mask(b.be));
        end
      end
      if (bus.resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, r.rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(r.err));
          chk("resp_latency", 32'(cyc - acc_cyc), 32'(r.lat));
          chk("beats_left", 32'(beat_q.size()), 32'd0);
        end
      end
    end
  end

  task automatic check_idle_outs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
    chk({tag, "_ram_strobes"}, 32'({bus.ram_we, bus.ram_re}), 32'd0);
    chk({tag, "_ram_type"}, 32'(bus.ram_type), 32'd0);
    chk({tag, "_ram_addr"}, bus.ram_addr, 32'd0);
    chk({tag, "_ram_wdat"}, bus.ram_wdat, 32'd0);
  endtask

  task automatic wait_ready();
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!bus.req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
  endtask

  // Predicts the access from byte addresses addr..addr+n-1, issues it, waits for completion.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit use_k, input logic [31:0] kval);
    resp_t       r;
    beat_t       b0, b1;
    int          n, lane, waitc;
    logic [31:0] a, val;
    logic        illegal;

    illegal = we ? (f3 > 3'd2) : (f3 inside {3'b011, 3'b110, 3'b111});
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    b0.addr = addr & 32'hFFFF_FFFC;
    b0.be = '0; b0.we = we; b0.wdat = '0;
    b1.addr = b0.addr + 32'd4;
    b1.be = '0; b1.we = we; b1.wdat = '0;
    val = '0;
    if (!illegal) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        lane = int'(a[1:0]);
        if ((a & 32'hFFFF_FFFC) == b0.addr) begin
          b0.be[lane] = 1'b1;
          b0.wdat[lane*8 +: 8] = wdata[i*8 +: 8];
        end else begin
          b1.be[lane] = 1'b1;
          b1.wdat[lane*8 +: 8] = wdata[i*8 +: 8];
        end
        if (we) ref_mem[a] = wdata[i*8 +: 8];
        else val[i*8 +: 8] = ref_rd(a);
      end
      if (n == 1) val = f3[2] ? {24'b0, val[7:0]} : {{24{val[7]}}, val[7:0]};
      if (n == 2) val = f3[2] ? {16'b0, val[15:0]} : {{16{val[15]}}, val[15:0]};
    end
    r.err   = illegal;
    r.rdata = (illegal || we) ? 32'd0 : (use_k ? kval : val);
    r.lat   = illegal ? 1 : ((we ? 2 : 3) + ((b1.be != 4'b0) ? 1 : 0));

    wait_ready();
    if (!illegal) begin
      beat_q.push_back(b0);
      if (b1.be != 4'b0) beat_q.push_back(b1);
    end
    resp_q.push_back(r);
    drive(we, f3, addr, wdata);

    waitc = 0;
    while (resp_q.size() != 0 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (resp_q.size() != 0) begin
      chk("resp_timeout", 32'(resp_q.size()), 32'd0);
      resp_q.delete();
      beat_q.delete();
    end
  endtask

  task automatic rq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata);
    issue(we, f3, addr, wdata, 1'b0, 32'd0);
  endtask

  task automatic rk(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] k);
    issue(1'b0, f3, addr, 32'd0, 1'b1, k);
  endtask

  localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (2) @(negedge clk);
    check_idle_outs("reset");
    rst_n = 1'b1;

    rq(1'b1, FW, 32'h1024_0043, 32'h123D_F556);
    rq(1'b1, FW, 32'h1024_0000, 32'h123D_F336);
    rk(FW, 32'h1024_0000, 32'h123D_F336);

    rq(1'b1, FW, 32'h0000_0100, 32'h80FF_7F01);
    rk(FB,  32'h0000_0103, 32'hFFFF_FF80);
    rk(FBU, 32'h0000_0103, 32'h0000_0080);
    rk(FH,  32'h0000_0102, 32'hFFFF_80FF);
    rk(FHU, 32'h0000_0101, 32'h0000_FF7F);

    rq(1'b1, FW, 32'h0000_0200, 32'h4433_2211);
    rq(1'b1, FW, 32'h0000_0204, 32'h8877_6655);
    rk(FW, 32'h0000_0202, 32'h6655_4433);
    rk(FH, 32'h0000_0203, 32'h0000_5544);

    rq(1'b1, FH, 32'hFFFF_FFFF, 32'h0000_ABCD);
    rk(FHU, 32'hFFFF_FFFF, 32'h0000_ABCD);

    rq(1'b0, 3'b011, 32'h0000_0100, 32'd0);
    rq(1'b1, 3'b100, 32'h0000_0100, 32'hDEAD_BEEF);

    // Reset while the second beat of a split load is on the bus.
    wait_ready();
    beat_q.push_back('{addr: 32'h0000_0200, be: 4'b1100, we: 1'b0, wdat: 32'd0});
    drive(1'b0, FW, 32'h0000_0202, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outs("midreset");
    beat_q.delete();
    resp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("postreset_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    rk(FW, 32'h0000_0202, 32'h6655_4433);

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = FB;
          1: f3 = FH;
          2: f3 = FW;
          3: f3 = FBU;
          default: f3 = FHU;
        endcase
      end
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else addr = 32'h0000_0300 + 32'($urandom_range(0, 63));
      rq(we, f3, addr, $urandom);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lsu_ram_master.md
Name: lsu_ram_master

Overview:
- Initiator side of the core's data-RAM port: takes one load/store request from the pipeline and drives the RAM strobes (ram_wdat, ram_we, ram_re, ram_type, ram_addr).
- The RAM word port takes a word-aligned address and a 4-bit byte-enable mask. Read data is registered, valid the cycle after ram_re.
- Generates byte enables and lane-shifted write data, and splits misaligned accesses into two word beats.
- Reassembles and sign/zero-extends load data, then returns a one-cycle response.

Parameters:
- None. Data and address widths are fixed at 32.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result (0 for stores and errors)
- resp_err  out  1  illegal funct3; valid with resp_valid
- ram_wdat  out  32  lane-aligned write data
- ram_we  out  1  write strobe
- ram_re  out  1  read strobe
- ram_type  out  4  byte enables; bit i = byte lane i
- ram_addr  out  32  word address, bits[1:0] always 00
- ram_rdata  in  32  RAM registered read data (data_reg)

Behaviour:
- Reset (asynchronous, rst_n=0): state = IDLE. All outputs 0 except req_ready=1. Internal buffers cleared.
- Reset mid-access: the request is dropped and no response is issued.
- States: IDLE, ACC0, ACC1, CAP, RESP.
- IDLE:
  - req_ready=1; all ram_* outputs are 0.
  - On req_valid, latch we/funct3/addr/wdata. off = addr[1:0].
  - Illegal funct3 (load 011/110/111, store >= 011) -> RESP with err=1; no RAM access.
  - Otherwise -> ACC0.
- Split condition: LH/LHU/SH with off=3, or LW/SW with off != 0.
- Beat addresses:
  - Beat0: ram_addr = {addr[31:2],2'b00}.
  - Beat1: beat0 + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- Byte mask: m = (0001 for B, 0011 for H, 1111 for W) as an 8-bit value shifted left by off.
  - Beat0 ram_type = m[3:0].
  - Beat1 ram_type = m[7:4].
- Write data: the 64-bit value {32'b0, wdata} << 8*off.
  - Beat0 ram_wdat = bits[31:0].
  - Beat1 ram_wdat = bits[63:32].
  - Lanes outside ram_type may carry any value; the RAM ignores them.
- ACC0: drive beat0 for exactly one cycle, with ram_we = store and ram_re = load.
  - Next state: split ? ACC1 : (load ? CAP : RESP).
- ACC1: drive beat1 for one cycle. A load captures ram_rdata (beat0 data) into buf0.
  - Next state: load ? CAP : RESP.
- CAP: strobes low; the last beat's data arrives on ram_rdata.
  - Form {hi,lo}: split gives {ram_rdata, buf0}, otherwise {32'b0, ram_rdata}.
  - Shift {hi,lo} right by 8*off and take 8/16/32 bits.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Register the result into resp_rdata. Next state: RESP.
- RESP: resp_valid=1 for one cycle; resp_rdata/resp_err hold their registered values. Next state: IDLE.
  - resp_rdata and resp_err are cleared on the transition back to IDLE.
- Handshake: req_valid is ignored outside IDLE. The requester holds its request until it sees req_ready, and there is no back-to-back acceptance.
- ram_we and ram_re are never high together and are high only in ACC0/ACC1.
- Latency from acceptance edge to resp_valid:
  - aligned store: 2 cycles
  - split store: 3 cycles
  - aligned load: 3 cycles
  - split load: 4 cycles
  - error: 1 cycle

Test Plan:
- SW 0x123DF556 @0x10240043 -> beat0: addr 0x10240040, type 1000, wdat[31:24]=0x56, we=1. Beat1: addr 0x10240044, type 0111, wdat[23:0]=0x123DF5. resp_valid 3 cycles after acceptance, err=0.
- SW 0x123DF336 @0x10240000, then LW @0x10240000 with RAM model -> one beat, type 1111; resp_rdata=0x123DF336 three cycles after load acceptance.
- Word 0x80FF7F01 at 0x100, then:
  - LB @0x103 -> 0xFFFFFF80
  - LBU @0x103 -> 0x00000080
  - LH @0x102 -> 0xFFFF80FF
  - LHU @0x101 -> 0x0000FF7F
- Words 0x44332211 @0x200 and 0x88776655 @0x204, then:
  - LW @0x202 -> two re beats (types 1100, 0011), resp_rdata=0x66554433
  - LH @0x203 -> 0x00005544
- Wrap: SH 0xABCD @0xFFFFFFFF -> beat0 addr 0xFFFFFFFC type 1000; beat1 addr 0x00000000 type 0001.
- Illegal load funct3=011 -> no ram_re/ram_we, resp_err=1 next cycle. Separately, pull rst_n low during ACC1 -> all outputs 0 immediately, no resp_valid, next request serviced normally.
